branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- MEM-stage consumer of the fetch-side predictions: checks each pipelined prediction against the real branch outcome.
- Registers a one-cycle redirect/flush to IF on a misprediction.
- Buffers predictor-table update records in a small FIFO, drained to the predictor tables over a valid/ready handshake.
- Sits between the MEM pipeline register and the branch predictor update port.

Parameters:
- DEPTH, 4, update FIFO entries; power of two, >= 2.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- mem_valid  in  1  MEM stage holds a live instruction this cycle.
- mem_is_br  in  1  conditional branch.
- mem_is_jmp  in  1  jal/jalr; always taken.
- mem_pc_out  in  32  PC of the MEM instruction.
- mem_alu_out  in  32  computed branch/jump target.
- mem_br_en  in  1  branch condition result.
- mem_predicted_pcmux_out  in  32  next PC used at fetch.
- mem_predicted_taken  in  1  fetch predicted taken.
- mem_BTB_hit  in  1  BTB hit at fetch.
- mem_predicted_counter  in  2  2-bit counter value read at fetch.
- upd_ready  in  1  predictor accepts an update.
- redirect_valid  out  1  one-cycle redirect/flush pulse.
- redirect_pc  out  32  correct next PC.
- upd_valid  out  1  FIFO head valid.
- upd_pc  out  32  head PC.
- upd_target  out  32  head actual target.
- upd_taken  out  1  head actual outcome.
- upd_counter  out  2  head new counter value.
- upd_alloc  out  1  head needs BTB allocation.
- stall_req  out  1  FIFO cannot accept; hold MEM.
- mem_misprediction  out  1  combinational mispredict flag for the current MEM instruction.

Behaviour:
- Reset (async, rst=1):
  - redirect_valid=0, redirect_pc=0.
  - FIFO empty: upd_valid=0, upd_* = 0.
  - stall_req=0; suppress flag=0; perf counters=0.
- Resolve (combinational, only when a branch is being resolved: mem_valid & (mem_is_br|mem_is_jmp) & !suppress):
  - actual_taken = mem_is_jmp | mem_br_en.
  - correct_pc = actual_taken ? mem_alu_out : mem_pc_out+4, mod 2^32.
  - mem_misprediction = (correct_pc != mem_predicted_pcmux_out).
- Counter update is a 2-bit saturating counter:
  - taken: min(c+1, 3).
  - not taken: max(c-1, 0).
  - Jumps always write 3.
- upd_alloc = actual_taken & !mem_BTB_hit.
- Redirect:
  - On a resolve with misprediction and no stall, the next cycle has redirect_valid=1 and redirect_pc=correct_pc, for exactly one cycle.
  - suppress is set the same edge and clears after one cycle, so a mem_valid in the cycle of the redirect pulse is wrong-path and is ignored: no update, no redirect.
- FIFO:
  - Every accepted resolve pushes {pc, target=mem_alu_out, taken, counter, alloc}.
  - Pop occurs when upd_valid & upd_ready.
  - upd_* are driven from the head register; entries are visible on upd_valid one cycle after push (no bypass).
  - Pointers are log2(DEPTH)+1 bits; full/empty come from MSB compare; pointers wrap modulo 2*DEPTH.
- Full / stall:
  - stall_req = resolve & full & !upd_ready.
  - A stalled resolve pushes nothing and does not redirect; the pipeline re-presents it next cycle.
  - Full with upd_ready=1: push and pop occur in the same cycle and the count is unchanged.
  - Empty: a push and upd_ready in the same cycle means push only, since there is no bypass.
- Non-branch instructions or mem_valid=0: no push, no redirect, mem_misprediction=0.
- Reset asserted mid-operation discards all FIFO entries and any pending redirect immediately.

Optional Feature:
- Macro BRANCH_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_branches[CNT_W] and perf_mispredicts[CNT_W].
  - Each increments by 1 per accepted resolve, and per accepted mispredicting resolve respectively.
  - Stalled and suppressed resolves are not counted.
  - Counters wrap at 2^CNT_W and reset to 0.
- When undefined: the ports and counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Correct prediction, taken BTB hit:
  - Stimulus: pc=0x100, alu=0x200, br_en=1, predicted=0x200, counter=2.
  - Required: no redirect; one push with taken=1, counter=3, alloc=0.
- Taken branch predicted not taken:
  - Stimulus: pc=0x100, br_en=1, alu=0x80, predicted=0x104, BTB_hit=0, counter=1.
  - Required: mem_misprediction=1; next cycle redirect_valid=1 with redirect_pc=0x80; push has counter=2, alloc=1.
  - Required: a branch presented during the redirect cycle is ignored.
- Not-taken branch predicted taken:
  - Stimulus: pc=0x40, br_en=0, predicted=0x90, counter=0.
  - Required: redirect_pc=0x44; pushed counter=0 (saturates low).
- FIFO full:
  - Stimulus: upd_ready=0 with 4 consecutive resolves, then a 5th resolve.
  - Required: stall_req=1 and no push for the 5th.
  - Stimulus: raise upd_ready.
  - Required: the 5th is accepted in the same cycle as the pop; drain order is FIFO.
- Wrap:
  - Stimulus: pc=0xFFFFFFFC, not taken, predicted=0x0.
  - Required: correct_pc=0x0, no misprediction.
- Reset:
  - Stimulus: assert rst with 3 entries queued and a redirect pending.
  - Required: upd_valid=0 and redirect_valid=0 immediately.
  - Perf build only: both perf counters read 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// =============================================================================
// Module      : branch_resolve_unit
// Description : MEM-stage branch resolution. Registers a redirect on a
//               mispredict; queues predictor updates in a FIFO.
//               Optional perf counters: define BRANCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_is_br,
    input  logic        mem_is_jmp,
    input  logic [31:0] mem_pc_out,
    input  logic [31:0] mem_alu_out,
    input  logic        mem_br_en,
    input  logic [31:0] mem_predicted_pcmux_out,
    input  logic        mem_predicted_taken,
    input  logic        mem_BTB_hit,
    input  logic [1:0]  mem_predicted_counter,
    input  logic        upd_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        upd_valid,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_target,
    output logic        upd_taken,
    output logic [1:0]  upd_counter,
    output logic        upd_alloc,
    output logic        stall_req,
    output logic        mem_misprediction
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
`endif
);

    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic [1:0]  counter;
        logic        alloc;
    } upd_rec_t;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_check
            $error("branch_resolve_unit: DEPTH must be a power of two >= 2 and CNT_W >= 1");
        end
    endgenerate

    logic              r_redirect_valid;
    logic [31:0]       r_redirect_pc;
    logic              r_suppress;
    logic [c_ADDR_W:0] r_wr_ptr;
    logic [c_ADDR_W:0] r_rd_ptr;
    upd_rec_t          r_fifo [DEPTH];

    logic        w_resolve;
    logic        w_actual_taken;
    logic [31:0] w_correct_pc;
    logic        w_mispredict;
    logic [1:0]  w_new_cnt;
    logic        w_full;
    logic        w_empty;
    logic        w_stall;
    logic        w_push;
    logic        w_pop;
    upd_rec_t    w_new_rec;
    upd_rec_t    w_head;
    logic        w_unused_ok;

    // The fetch-side taken bit is implied by the predicted PC, so it is not needed here.
    assign w_unused_ok = mem_predicted_taken;

    assign w_resolve      = mem_valid & (mem_is_br | mem_is_jmp) & ~r_suppress;
    assign w_actual_taken = mem_is_jmp | mem_br_en;
    assign w_correct_pc   = w_actual_taken ? mem_alu_out : (mem_pc_out + 32'd4);
    assign w_mispredict   = w_resolve & (w_correct_pc != mem_predicted_pcmux_out);

    always_comb begin
        w_new_cnt = mem_predicted_counter;
        if (mem_is_jmp) begin
            w_new_cnt = 2'b11;
        end else if (w_actual_taken) begin
            if (mem_predicted_counter != 2'b11) w_new_cnt = mem_predicted_counter + 2'd1;
        end else begin
            if (mem_predicted_counter != 2'b00) w_new_cnt = mem_predicted_counter - 2'd1;
        end
    end

    always_comb begin
        w_new_rec         = '0;
        w_new_rec.pc      = mem_pc_out;
        w_new_rec.target  = mem_alu_out;
        w_new_rec.taken   = w_actual_taken;
        w_new_rec.counter = w_new_cnt;
        w_new_rec.alloc   = w_actual_taken & ~mem_BTB_hit;
    end

    // Full when the wrap bits differ but the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                     (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    assign w_pop   = ~w_empty & upd_ready;
    assign w_stall = w_resolve & w_full & ~upd_ready;
    assign w_push  = w_resolve & ~w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: every read is gated by the empty flag.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr[c_ADDR_W-1:0]] <= w_new_rec;
    end

    assign w_head = r_fifo[r_rd_ptr[c_ADDR_W-1:0]];

    always_comb begin
        upd_valid   = ~w_empty;
        upd_pc      = '0;
        upd_target  = '0;
        upd_taken   = 1'b0;
        upd_counter = '0;
        upd_alloc   = 1'b0;
        if (!w_empty) begin
            upd_pc      = w_head.pc;
            upd_target  = w_head.target;
            upd_taken   = w_head.taken;
            upd_counter = w_head.counter;
            upd_alloc   = w_head.alloc;
        end
    end

    // The suppress window marks the instruction behind a redirect as wrong-path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_suppress       <= 1'b0;
        end else begin
            r_redirect_valid <= w_push & w_mispredict;
            r_suppress       <= w_push & w_mispredict;
            if (w_push & w_mispredict) r_redirect_pc <= w_correct_pc;
        end
    end

    assign redirect_valid    = r_redirect_valid;
    assign redirect_pc       = r_redirect_pc;
    assign stall_req         = w_stall;
    assign mem_misprediction = w_mispredict;

`ifdef BRANCH_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_branches;
    logic [CNT_W-1:0] r_perf_mispredicts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_branches    <= '0;
            r_perf_mispredicts <= '0;
        end else begin
            if (w_push)                r_perf_branches    <= r_perf_branches + 1'b1;
            if (w_push & w_mispredict) r_perf_mispredicts <= r_perf_mispredicts + 1'b1;
        end
    end

    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// =============================================================================
// Module      : tb_branch_resolve_unit
// Description : Scoreboard bench for branch_resolve_unit (BRANCH_PERF_CNT_EN aware).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_is_br;
    logic        mem_is_jmp;
    logic [31:0] mem_pc_out;
    logic [31:0] mem_alu_out;
    logic        mem_br_en;
    logic [31:0] mem_predicted_pcmux_out;
    logic        mem_predicted_taken;
    logic        mem_BTB_hit;
    logic [1:0]  mem_predicted_counter;
    logic        upd_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [1:0]  upd_counter;
    logic        upd_alloc;
    logic        stall_req;
    logic        mem_misprediction;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
    int          exp_branches;
    int          exp_mispredicts;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic [1:0]  counter;
        logic        alloc;
    } upd_t;

    upd_t sb[$];
    int   n_checks;
    int   n_fail;

    branch_resolve_unit #(.DEPTH(4), .CNT_W(32)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .mem_valid               (mem_valid),
        .mem_is_br               (mem_is_br),
        .mem_is_jmp              (mem_is_jmp),
        .mem_pc_out              (mem_pc_out),
        .mem_alu_out             (mem_alu_out),
        .mem_br_en               (mem_br_en),
        .mem_predicted_pcmux_out (mem_predicted_pcmux_out),
        .mem_predicted_taken     (mem_predicted_taken),
        .mem_BTB_hit             (mem_BTB_hit),
        .mem_predicted_counter   (mem_predicted_counter),
        .upd_ready               (upd_ready),
        .redirect_valid          (redirect_valid),
        .redirect_pc             (redirect_pc),
        .upd_valid               (upd_valid),
        .upd_pc                  (upd_pc),
        .upd_target              (upd_target),
        .upd_taken               (upd_taken),
        .upd_counter             (upd_counter),
        .upd_alloc               (upd_alloc),
        .stall_req               (stall_req),
        .mem_misprediction       (mem_misprediction)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .perf_branches           (perf_branches),
        .perf_mispredicts        (perf_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pops happen at the next rising edge; compare the head against the oldest expectation.
    always @(negedge clk) begin
        upd_t got;
        upd_t exp;
        if (!rst && upd_valid && upd_ready) begin
            n_checks++;
            got = {upd_pc, upd_target, upd_taken, upd_counter, upd_alloc};
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_update: got pc=%h target=%h, required no entry", upd_pc, upd_target);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL sb_update: got pc=%h tgt=%h tk=%b cnt=%0d al=%b, required pc=%h tgt=%h tk=%b cnt=%0d al=%b",
                             got.pc, got.target, got.taken, got.counter, got.alloc,
                             exp.pc, exp.target, exp.taken, exp.counter, exp.alloc);
                end
            end
        end
    end

    function automatic upd_t mk(input logic [31:0] pc, input logic [31:0] tgt,
                                input logic tk, input logic [1:0] cnt, input logic al);
        mk = {pc, tgt, tk, cnt, al};
    endfunction

    task automatic note_accept(input logic mis);
`ifdef BRANCH_PERF_CNT_EN
        exp_branches++;
        if (mis) exp_mispredicts++;
`else
        if (mis) begin end
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_valid  = 1'b0;
        mem_is_br  = 1'b0;
        mem_is_jmp = 1'b0;
        mem_br_en  = 1'b0;
    endtask

    task automatic present(input logic is_br, input logic is_jmp, input logic [31:0] pc,
                           input logic [31:0] alu, input logic br_en, input logic [31:0] pred,
                           input logic hit, input logic [1:0] cnt);
        mem_valid               = 1'b1;
        mem_is_br               = is_br;
        mem_is_jmp              = is_jmp;
        mem_pc_out              = pc;
        mem_alu_out             = alu;
        mem_br_en               = br_en;
        mem_predicted_pcmux_out = pred;
        mem_predicted_taken     = (pred != pc + 32'd4);
        mem_BTB_hit             = hit;
        mem_predicted_counter   = cnt;
    endtask

    task automatic chk1(input string name, input logic got, input logic req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain_timeout: got %0d pending, required 0", name, sb.size());
            sb.delete();
        end
        chk1({name, "_fifo_empty"}, upd_valid, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        upd_ready = 1'b1;
        mem_pc_out = '0;
        mem_alu_out = '0;
        mem_predicted_pcmux_out = '0;
        mem_predicted_taken = 1'b0;
        mem_BTB_hit = 1'b0;
        mem_predicted_counter = '0;
        #12;
        chk1("reset_redirect_valid", redirect_valid, 1'b0);
        chk32("reset_redirect_pc", redirect_pc, 32'h0);
        chk1("reset_upd_valid", upd_valid, 1'b0);
        chk32("reset_upd_pc", upd_pc, 32'h0);
        chk1("reset_stall_req", stall_req, 1'b0);
`ifdef BRANCH_PERF_CNT_EN
        chk32("reset_perf_branches", perf_branches, 32'h0);
        exp_branches = 0;
        exp_mispredicts = 0;
`endif
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_correct_taken();
        present(1'b1, 1'b0, 32'h100, 32'h200, 1'b1, 32'h200, 1'b1, 2'd2);
        #3;
        chk1("correct_mispred", mem_misprediction, 1'b0);
        sb.push_back(mk(32'h100, 32'h200, 1'b1, 2'd3, 1'b0));
        note_accept(1'b0);
        step();
        idle();
        chk1("correct_no_redirect", redirect_valid, 1'b0);
        wait_drain("correct");
    endtask

    task automatic test_taken_mispredict();
        present(1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 32'h104, 1'b0, 2'd1);
        #3;
        chk1("tk_mispred_flag", mem_misprediction, 1'b1);
        sb.push_back(mk(32'h100, 32'h80, 1'b1, 2'd2, 1'b1));
        note_accept(1'b1);
        step();
        chk1("tk_redirect_valid", redirect_valid, 1'b1);
        chk32("tk_redirect_pc", redirect_pc, 32'h80);
        // Wrong-path branch during the redirect pulse: must vanish.
        present(1'b1, 1'b0, 32'h300, 32'h700, 1'b1, 32'h304, 1'b1, 2'd1);
        #3;
        chk1("suppress_mispred_flag", mem_misprediction, 1'b0);
        step();
        idle();
        chk1("suppress_no_redirect", redirect_valid, 1'b0);
        wait_drain("tk_mispred");
    endtask

    task automatic test_not_taken_mispredict();
        present(1'b1, 1'b0, 32'h40, 32'h1234, 1'b0, 32'h90, 1'b1, 2'd0);
        #3;
        chk1("nt_mispred_flag", mem_misprediction, 1'b1);
        sb.push_back(mk(32'h40, 32'h1234, 1'b0, 2'd0, 1'b0));
        note_accept(1'b1);
        step();
        idle();
        chk1("nt_redirect_valid", redirect_valid, 1'b1);
        chk32("nt_redirect_pc", redirect_pc, 32'h44);
        step();
        chk1("nt_redirect_one_cycle", redirect_valid, 1'b0);
        wait_drain("nt_mispred");
    endtask

    task automatic test_wrap_jump_nonbranch();
        present(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h4000, 1'b0, 32'h0, 1'b0, 2'd3);
        #3;
        chk1("wrap_mispred", mem_misprediction, 1'b0);
        sb.push_back(mk(32'hFFFF_FFFC, 32'h4000, 1'b0, 2'd2, 1'b0));
        note_accept(1'b0);
        step();
        chk1("wrap_no_redirect", redirect_valid, 1'b0);
        // Jump with br_en low: still taken, counter forced to 3, allocates on BTB miss.
        present(1'b0, 1'b1, 32'h600, 32'h500, 1'b0, 32'h500, 1'b0, 2'd1);
        #3;
        chk1("jmp_mispred", mem_misprediction, 1'b0);
        sb.push_back(mk(32'h600, 32'h500, 1'b1, 2'd3, 1'b1));
        note_accept(1'b0);
        step();
        present(1'b0, 1'b0, 32'h700, 32'h0, 1'b1, 32'h999, 1'b0, 2'd1);
        #3;
        chk1("nonbranch_mispred", mem_misprediction, 1'b0);
        step();
        chk1("nonbranch_no_redirect", redirect_valid, 1'b0);
        present(1'b1, 1'b0, 32'h800, 32'h0, 1'b1, 32'h999, 1'b0, 2'd1);
        mem_valid = 1'b0;
        #3;
        chk1("invalid_mispred", mem_misprediction, 1'b0);
        step();
        idle();
        chk1("invalid_no_redirect", redirect_valid, 1'b0);
        wait_drain("wrap_jmp");
    endtask

    task automatic test_fifo_full();
        logic [31:0] pc;
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h1000 + 32'(i * 16);
            present(1'b1, 1'b0, pc, 32'h2000 + 32'(i), 1'b0, pc + 32'd4, 1'b1, 2'(i));
            #3;
            chk1("full_fill_stall", stall_req, 1'b0);
            sb.push_back(mk(pc, 32'h2000 + 32'(i), 1'b0, (i == 0) ? 2'd0 : 2'(i - 1), 1'b0));
            note_accept(1'b0);
            step();
        end
        present(1'b1, 1'b0, 32'h1040, 32'h2004, 1'b1, 32'h2004, 1'b1, 2'd2);
        #3;
        chk1("full_stall_req", stall_req, 1'b1);
        chk1("full_stall_mispred", mem_misprediction, 1'b0);
        step();
        chk1("full_stall_held", stall_req, 1'b1);
        chk32("full_head_pc", upd_pc, 32'h1000);
        upd_ready = 1'b1;
        #1;
        chk1("full_ready_no_stall", stall_req, 1'b0);
        sb.push_back(mk(32'h1040, 32'h2004, 1'b1, 2'd3, 1'b0));
        note_accept(1'b0);
        step();
        idle();
        chk32("full_head_after_pop", upd_pc, 32'h1010);
        wait_drain("full");
    endtask

    task automatic test_reset_midop();
        upd_ready = 1'b0;
        present(1'b1, 1'b0, 32'h2100, 32'h2200, 1'b1, 32'h2200, 1'b1, 2'd2);
        step();
        present(1'b1, 1'b0, 32'h2110, 32'h2300, 1'b0, 32'h2114, 1'b1, 2'd2);
        step();
        present(1'b1, 1'b0, 32'h2120, 32'h2400, 1'b1, 32'h2124, 1'b0, 2'd1);
        note_accept(1'b0);
        note_accept(1'b0);
        note_accept(1'b1);
        step();
        idle();
        chk1("midrst_pre_redirect", redirect_valid, 1'b1);
        chk1("midrst_pre_upd_valid", upd_valid, 1'b1);
`ifdef BRANCH_PERF_CNT_EN
        chk32("perf_branches_total", perf_branches, 32'(exp_branches));
        chk32("perf_mispredicts_total", perf_mispredicts, 32'(exp_mispredicts));
`endif
        rst = 1'b1;
        #1;
        chk1("midrst_upd_valid", upd_valid, 1'b0);
        chk1("midrst_redirect_valid", redirect_valid, 1'b0);
`ifdef BRANCH_PERF_CNT_EN
        chk32("midrst_perf_branches", perf_branches, 32'h0);
        chk32("midrst_perf_mispredicts", perf_mispredicts, 32'h0);
`endif
        sb.delete();
        step();
        rst = 1'b0;
        upd_ready = 1'b1;
        step();
        chk1("postrst_upd_valid", upd_valid, 1'b0);
        chk1("postrst_redirect_valid", redirect_valid, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_correct_taken();
        test_taken_mispredict();
        test_not_taken_mispredict();
        test_wrap_jump_nonbranch();
        test_fifo_full();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
